// File: rtl/coef_table_server.sv
// Two-bank coefficient table: fills itself with reciprocal-style defaults after
// reset, then serves single-cycle reads and writes. Reads take priority over writes.
module coef_table_server #(
    parameter int CNT_WIDTH    = 4,
    parameter int F_WIDTH      = 8,
    parameter int NUM_OF_TERMS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 busy,
    input  logic                 rd_req,
    input  logic                 rd_bank,
    input  logic [CNT_WIDTH-1:0] rd_addr,
    output logic                 rd_ack,
    output logic [F_WIDTH-1:0]   rd_data,
    output logic                 rd_err,
    input  logic                 wr_req,
    input  logic                 wr_bank,
    input  logic [CNT_WIDTH-1:0] wr_addr,
    input  logic [F_WIDTH-1:0]   wr_data,
    output logic                 wr_ack
);
    localparam int IDX_W = CNT_WIDTH + 1;
    localparam int DEPTH = 2 * NUM_OF_TERMS;
    localparam longint unsigned M_VAL = (64'd1 << F_WIDTH) - 64'd1;

    typedef enum logic {INIT, READY} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [F_WIDTH-1:0] mem_q   [DEPTH];
    logic [F_WIDTH-1:0] def_tab [DEPTH];

    logic               rd_ack_q, rd_ack_d;
    logic               rd_err_q, rd_err_d;
    logic [F_WIDTH-1:0] rd_data_q, rd_data_d;
    logic               wr_ack_q, wr_ack_d;

    logic               rd_fire, wr_fire, wr_commit;
    logic               rd_in_range, wr_in_range;
    logic [IDX_W-1:0]   rd_idx, wr_idx;
    logic [F_WIDTH-1:0] rd_word;

    // Defaults are elaboration-time constants; bank 1 occupies the upper half.
    for (genvar gi = 0; gi < NUM_OF_TERMS; gi++) begin : g_def
        assign def_tab[gi]                = F_WIDTH'(M_VAL / 64'(gi + 1));
        assign def_tab[NUM_OF_TERMS + gi] = F_WIDTH'(M_VAL / 64'(2 * gi + 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        case (state_q)
            INIT: begin
                busy  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            end
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        rd_in_range = {1'b0, rd_addr} < IDX_W'(NUM_OF_TERMS);
        wr_in_range = {1'b0, wr_addr} < IDX_W'(NUM_OF_TERMS);
        rd_idx      = rd_bank ? IDX_W'(NUM_OF_TERMS) + {1'b0, rd_addr} : {1'b0, rd_addr};
        wr_idx      = wr_bank ? IDX_W'(NUM_OF_TERMS) + {1'b0, wr_addr} : {1'b0, wr_addr};
        rd_word     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == IDX_W'(i)) rd_word = mem_q[i];
        end
        rd_fire   = (state_q == READY) && rd_req;
        wr_fire   = (state_q == READY) && wr_req && !rd_req;
        wr_commit = wr_fire && wr_in_range;
        rd_ack_d  = rd_fire;
        rd_err_d  = rd_fire && !rd_in_range;
        rd_data_d = rd_data_q;
        if (rd_fire) rd_data_d = rd_in_range ? rd_word : '0;
        // Out-of-range writes are still acknowledged so the writer can move on.
        wr_ack_d  = wr_fire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
            wr_ack_q  <= 1'b0;
        end else begin
            rd_ack_q  <= rd_ack_d;
            rd_err_q  <= rd_err_d;
            rd_data_q <= rd_data_d;
            wr_ack_q  <= wr_ack_d;
        end
    end

    // Writes never coincide with reads, so a read always sees settled flop contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (state_q == INIT && cnt_q == IDX_W'(i)) begin
                mem_q[i] <= def_tab[i];
            end else if (wr_commit && wr_idx == IDX_W'(i)) begin
                mem_q[i] <= wr_data;
            end
        end
    end

    assign rd_ack  = rd_ack_q;
    assign rd_err  = rd_err_q;
    assign rd_data = rd_data_q;
    assign wr_ack  = wr_ack_q;

endmodule

// File: tb/tb_coef_table_server.sv
// Bench for coef_table_server: directed scenarios plus random traffic checked
// against an array-based model of the table and its handshake timing.
module tb_coef_table_server;
    logic       clk = 1'b0;
    logic       rst, busy;
    logic       rd_req, rd_bank, rd_ack, rd_err;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_req, wr_bank, wr_ack;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int model_mem [2][8];
    int init_left = 0;
    bit e_busy, e_rack, e_err, e_wack;
    int e_data = 0;

    coef_table_server dut (
        .clk(clk), .rst(rst), .busy(busy),
        .rd_req(rd_req), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .rd_err(rd_err),
        .wr_req(wr_req), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic load_defaults();
        for (int i = 0; i < 8; i++) begin
            model_mem[0][i] = 255 / (i + 1);
            model_mem[1][i] = 255 / (2 * i + 1);
        end
    endtask

    // One clock: drive at the falling edge, predict, check at the next falling edge.
    task automatic cyc(input bit r, input bit rq, input bit rb, input int ra,
                       input bit wq, input bit wb, input int wa, input int wd);
        rst = r; rd_req = rq; rd_bank = rb; rd_addr = 4'(ra);
        wr_req = wq; wr_bank = wb; wr_addr = 4'(wa); wr_data = 8'(wd);
        if (r) begin
            e_busy = 1; e_rack = 0; e_err = 0; e_wack = 0; e_data = 0;
            init_left = 16;
            load_defaults();
        end else if (init_left > 0) begin
            init_left--;
            e_busy = (init_left > 0); e_rack = 0; e_err = 0; e_wack = 0;
        end else begin
            e_busy = 0;
            e_rack = rq;
            e_err  = rq && (ra >= 8);
            if (rq) e_data = (ra < 8) ? model_mem[rb][ra] : 0;
            e_wack = wq && !rq;
            if (e_wack && wa < 8) model_mem[wb][wa] = wd;
        end
        @(negedge clk);
        check_val("busy", busy, e_busy);
        check_val("rd_ack", rd_ack, e_rack);
        check_val("rd_err", rd_err, e_err);
        check_val("rd_data", rd_data, e_data);
        check_val("wr_ack", wr_ack, e_wack);
        if (e_rack) $display("rd bank%0d addr%0d -> %02h err=%0d", rb, ra, rd_data, rd_err);
        if (e_wack) $display("wr bank%0d addr%0d <- %02h", wb, wa, wd);
    endtask

    task automatic wait_ready(input bit rq_during);
        int n = 0;
        while (n < 40) begin
            cyc(0, rq_during, 0, n % 8, rq_during, 1, 2, 8'h33);
            n++;
            if (busy == 1'b0) break;
        end
        check_val("init_len", 32'(n), 32'd16);
    endtask

    initial begin
        bit pend = 0;
        bit pb = 0;
        int pa = 0;
        int pd = 0;
        @(negedge clk);
        cyc(1, 1, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        // Requests during INIT must be ignored until READY
        wait_ready(1);

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 8; a++) cyc(0, 1, b[0], a, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        // Spot-check a few defaults against literal values
        cyc(0, 1, 0, 2, 0, 0, 0, 0);
        check_val("def_b0_2", rd_data, 8'd85);
        cyc(0, 1, 1, 4, 0, 0, 0, 0);
        check_val("def_b1_4", rd_data, 8'd28);

        cyc(0, 0, 0, 0, 1, 1, 3, 8'hA5);
        cyc(0, 1, 1, 3, 0, 0, 0, 0);
        check_val("rd_after_wr", rd_data, 8'hA5);

        cyc(0, 1, 0, 5, 1, 0, 6, 8'h5A);
        cyc(0, 1, 0, 6, 1, 0, 6, 8'h5A);
        cyc(0, 0, 0, 0, 1, 0, 6, 8'h5A);
        cyc(0, 1, 0, 6, 0, 0, 0, 0);

        cyc(0, 1, 0, 9, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 12, 8'hEE);
        cyc(0, 0, 0, 0, 1, 1, 15, 8'hEE);
        for (int a = 0; a < 8; a++) cyc(0, 1, 0, a, 0, 0, 0, 0);
        cyc(0, 1, 1, 15, 0, 0, 0, 0);

        // Random traffic; the writer holds its operands until acknowledged
        for (int k = 0; k < 600; k++) begin
            bit rq = ($urandom_range(0, 1) == 1);
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1; pb = $urandom_range(0, 1) == 1;
                pa = $urandom_range(0, 15); pd = $urandom_range(0, 255);
            end
            if ($urandom_range(0, 199) == 0) begin
                cyc(1, 0, 0, 0, 0, 0, 0, 0);
                pend = 0;
                wait_ready(0);
            end else begin
                cyc(0, rq, $urandom_range(0, 1) == 1, $urandom_range(0, 15), pend, pb, pa, pd);
                if (e_wack) pend = 0;
            end
        end

        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 8'h10);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        check_val("ovr_b0_0", rd_data, 8'h10);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        wait_ready(0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        check_val("restored_b0_0", rd_data, 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/coef_table_server.md
COEF_TABLE_SERVER -- requirements
Module: coef_table_server

Interface
REQ-001 Parameter CNT_WIDTH, default 4: coefficient address width.
REQ-002 Parameter F_WIDTH, default 8: coefficient width, unsigned fraction, binary point left of MSB.
REQ-003 Parameter NUM_OF_TERMS, default 8: entries per bank, at most 2^CNT_WIDTH.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 busy  output  1  high while the default table is being initialised.
REQ-007 rd_req  input  1  read request, sampled each cycle.
REQ-008 rd_bank  input  1  bank select, matching the func[0] convention (0 = bank 0, 1 = bank 1).
REQ-009 rd_addr  input  CNT_WIDTH  term index.
REQ-010 rd_ack  output  1  one-cycle pulse: rd_data valid.
REQ-011 rd_data  output  F_WIDTH  returned coefficient.
REQ-012 rd_err  output  1  one-cycle pulse together with rd_ack when the address was out of range.
REQ-013 wr_req  input  1  coefficient overwrite request.
REQ-014 wr_bank  input  1  target bank.
REQ-015 wr_addr  input  CNT_WIDTH  target index.
REQ-016 wr_data  input  F_WIDTH  new coefficient.
REQ-017 wr_ack  output  1  one-cycle pulse: the write was committed.

Function
REQ-018 The block SHALL store 2 x NUM_OF_TERMS coefficients of F_WIDTH bits each.
REQ-019 The FSM SHALL have exactly two states, INIT and READY.
REQ-020 INIT SHALL write one default entry per cycle, walking a counter from 0 to 2*NUM_OF_TERMS-1.
  - Bank 0 is written first, then bank 1.
  - busy is high throughout INIT.
REQ-021 Default values, where M = 2^F_WIDTH-1 and the division truncates:
  - bank 0, entry i = floor(M/(i+1)).
  - bank 1, entry i = floor(M/(2i+1)).
REQ-022 With the default parameters these defaults SHALL be:
  - bank 0: 255,127,85,63,51,42,36,31.
  - bank 1: 255,85,51,36,28,23,19,17.
REQ-023 After the last INIT write, the FSM SHALL move to READY on the next edge and busy SHALL fall in the same cycle.
REQ-024 In INIT, rd_req and wr_req SHALL be ignored and produce no ack.
REQ-025 In READY, each cycle with rd_req=1 SHALL produce rd_ack=1 exactly one cycle later.
  - rd_data carries the entry at (rd_bank, rd_addr) as sampled with the request.
  - Back-to-back requests give back-to-back acks, so throughput is 1 per cycle.
REQ-026 If rd_addr >= NUM_OF_TERMS, rd_data SHALL be 0 and rd_err SHALL pulse with rd_ack.
REQ-027 rd_data SHALL hold its last value while rd_ack=0.
REQ-028 In READY, wr_req=1 with rd_req=0 SHALL update the entry at the edge and pulse wr_ack the following cycle.
REQ-029 If rd_req and wr_req are both high in the same cycle, the read SHALL win.
  - The write is not committed and wr_ack stays 0.
  - The writer holds wr_req and its operands until wr_ack is seen.
REQ-030 A write with wr_addr >= NUM_OF_TERMS SHALL be discarded, but wr_ack SHALL still pulse so the writer is not deadlocked.
REQ-031 A read issued the cycle after a committed write to the same entry SHALL return the new value.
REQ-032 Storage SHALL be flop-based, with no read-during-write ambiguity.

Reset
REQ-033 While rst=1, the outputs SHALL be:
  - busy=1;
  - rd_ack=0, rd_err=0, rd_data=0;
  - wr_ack=0.
REQ-034 While rst=1, the FSM SHALL be held in INIT with the counter at 0.
REQ-035 rst asserted mid-operation SHALL abort any pending ack and discard all overwritten coefficients; the full INIT sequence reruns after rst falls.
REQ-036 INIT SHALL take exactly 2*NUM_OF_TERMS cycles after rst deasserts (16 with the defaults), and busy SHALL be 0 from cycle 17.

Verification
REQ-037 Release reset and count cycles until busy falls, then read all 16 entries back-to-back -> busy low at cycle 17; 16 consecutive acks return the default values of REQ-022 in order.
REQ-038 Write 8'hA5 to bank 1 addr 3, then read bank 1 addr 3 in the next cycle -> wr_ack, then rd_ack with rd_data=8'hA5.
REQ-039 Raise rd_req and wr_req in the same cycle, with wr_req held -> read acks first; wr_ack arrives one cycle after rd_req drops.
REQ-040 Read addr 9 -> rd_ack=1, rd_err=1, rd_data=0; write addr 12 -> wr_ack=1 and no entry changes.
REQ-041 Overwrite bank 0 addr 0 with 8'h10, assert rst for 1 cycle, wait for busy to fall, then read bank 0 addr 0 -> 8'hFF (default restored).
REQ-042 Assert rd_req during INIT -> no rd_ack until READY.
